// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared types and constants for the peripheral bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: arbiter FSM encoding, peripheral decode width, default bus widths, master id type.
package periph_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_t;

  // The peripheral decodes only the low 22 address bits.
  localparam int PERIPH_ADDR_LEN = 22;
  localparam int BUS_ADDR_W      = 32;
  localparam int BUS_DATA_W      = 32;

  // Two masters, so a master id is a single bit.
  typedef logic mid_t;

endpackage

// File: rtl/periph_bus_arbiter_if.sv
// periph_bus_arbiter_if: one master's request/response bundle toward the arbiter.
// Latency: gnt is same-cycle; rvalid/rdata arrive one cycle after a read's gnt.
// Backpressure: master holds req (and wr/addr/wdata) until gnt is seen.
// Modports: master (drives req/wr/addr/wdata/lock), slave (arbiter side, drives gnt/rvalid/rdata).
interface periph_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, wr, addr, wdata, lock,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/periph_bus_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker; on a tie the master that did not win last time wins.
// Latency: purely combinational.
// Backpressure: none; the loser simply sees no grant and keeps requesting.
// Ports: req[1:0] requests, last = id of previous winner, gnt[1:0] one-hot (or zero) grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: shares the single-port peripheral register bus between m0 (CPU LSU) and m1 (debug/DMA).
// Latency: grant same cycle as req; read data returned to the owner one cycle after the read's grant.
// Backpressure: losing master holds req until granted; one transfer accepted per cycle, fully pipelined.
// Ports: clk, rst (async, active-high); m0/m1 slave-side bus interfaces; p_addr/p_wr/p_wdata to the
//   peripheral, p_rdata from it (registered in the peripheral).
// Optional bus locking is built only when PERIPH_ARB_LOCK_EN is defined; otherwise m*.lock is ignored.
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int ADDR_W   = BUS_ADDR_W,
  parameter int DATA_W   = BUS_DATA_W,
  parameter int LOCK_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  periph_bus_arbiter_if.slave m0,
  periph_bus_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   p_addr,
  output logic                p_wr,
  output logic [DATA_W-1:0]   p_wdata,
  input  logic [DATA_W-1:0]   p_rdata
);

  logic [1:0]        rr_gnt;
  logic [1:0]        gnt;
  logic              any_gnt;
  mid_t              winner;
  mid_t              last;
  logic              rtag_v;
  mid_t              rtag;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  arb_state_t        state;

  rr_arb2 u_rr (
    .req  ({m1.req, m0.req}),
    .last (last),
    .gnt  (rr_gnt)
  );

`ifdef PERIPH_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t       state_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt, cnt_inc;
  logic             own_req, own_lock;

  assign own_req  = (state == ARB_LOCK1) ? m1.req  : m0.req;
  assign own_lock = (state == ARB_LOCK1) ? m1.lock : m0.lock;
  assign cnt_inc  = lock_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // lock_cnt counts grants taken inside the current lock, including the one
  // being accepted; the grant that brings it to LOCK_MAX is the last one.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    case (state)
      ARB_IDLE: begin
        if (any_gnt && (winner ? m1.lock : m0.lock) && (LOCK_MAX > 1)) begin
          state_nxt    = winner ? ARB_LOCK1 : ARB_LOCK0;
          lock_cnt_nxt = CNT_W'(1);
        end
      end
      ARB_LOCK0, ARB_LOCK1: begin
        if (any_gnt) begin
          lock_cnt_nxt = cnt_inc;
          if (!own_lock || (cnt_inc == CNT_W'(LOCK_MAX))) begin
            state_nxt = ARB_IDLE;
          end
        end else if (!own_req && !own_lock) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end
`else
  localparam int UNUSED_LOCK_MAX = LOCK_MAX;
  logic unused_lock;

  assign state       = ARB_IDLE;
  assign unused_lock = m0.lock ^ m1.lock;
`endif

  // Grant decode: while locked only the owner can be granted. Reset kills
  // grants immediately so nothing reaches the peripheral during reset.
  always_comb begin
    case (state)
      ARB_LOCK0: gnt = {1'b0, m0.req};
      ARB_LOCK1: gnt = {m1.req, 1'b0};
      default:   gnt = rr_gnt;
    endcase
    if (rst) begin
      gnt = 2'b00;
    end
  end

  assign any_gnt = |gnt;
  assign winner  = gnt[1];
  assign m0.gnt  = gnt[0];
  assign m1.gnt  = gnt[1];

  always_comb begin
    p_addr  = '0;
    p_wr    = 1'b0;
    p_wdata = '0;
    if (gnt[0]) begin
      p_addr  = m0.addr;
      p_wr    = m0.wr;
      p_wdata = m0.wdata;
    end else if (gnt[1]) begin
      p_addr  = m1.addr;
      p_wr    = m1.wr;
      p_wdata = m1.wdata;
    end
  end

  // Read tag: the peripheral returns data one cycle after the read is
  // accepted, so remember who asked and route p_rdata there next cycle.
  assign rvalid0 = rtag_v && (rtag == 1'b0);
  assign rvalid1 = rtag_v && (rtag == 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last     <= 1'b1;
      rtag_v   <= 1'b0;
      rtag     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rtag_v <= any_gnt && !p_wr;
      if (any_gnt) begin
        last <= winner;
        rtag <= winner;
      end
      if (rvalid0) rdata0_q <= p_rdata;
      if (rvalid1) rdata1_q <= p_rdata;
    end
  end

  // rdata shows live peripheral data while valid, then holds it.
  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.rdata  = rvalid0 ? p_rdata : rdata0_q;
  assign m1.rdata  = rvalid1 ? p_rdata : rdata1_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: directed plus random checks of periph_bus_arbiter against a behavioural model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
// A small register-file peripheral (LEDR at 0, GPIO at 1, else reads 0) sits behind the arbiter.
module tb_periph_bus_arbiter;

  localparam int LMAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic        p_wr;

  always #5 clk = ~clk;

  periph_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  periph_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

  periph_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LMAX)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_if.slave),
    .m1      (m1_if.slave),
    .p_addr  (p_addr),
    .p_wr    (p_wr),
    .p_wdata (p_wdata),
    .p_rdata (p_rdata)
  );

  // Peripheral stand-in: registered read data, decode on addr[21:0].
  logic [9:0]  per_ledr;
  logic [31:0] per_gpio;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      per_ledr <= '0;
      per_gpio <= '0;
      p_rdata  <= '0;
    end else begin
      if (p_wr && p_addr[21:0] == 22'd0) per_ledr <= p_wdata[9:0];
      if (p_wr && p_addr[21:0] == 22'd1) per_gpio <= p_wdata;
      p_rdata <= (p_addr[21:0] == 22'd0) ? {22'd0, per_ledr} :
                 (p_addr[21:0] == 22'd1) ? per_gpio : 32'd0;
    end
  end

  // Reference model state.
  int          checks = 0;
  int          errors = 0;
  int          m_last;
  int          lk_owner;
  int          lk_n;
  bit          pv;
  int          ptag;
  logic [31:0] pdat;
  logic [31:0] sh_ledr, sh_gpio;
  logic [31:0] exp_rdata [2];
  int          gseq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[21:0] == 22'd0) return sh_ledr;
    if (a[21:0] == 22'd1) return sh_gpio;
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_last = 1; lk_owner = -1; lk_n = 0; pv = 0; ptag = 0; pdat = '0;
    sh_ledr = '0; sh_gpio = '0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
  endtask

  task automatic drive(input int n, input bit req, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit lock);
    if (n == 0) begin
      m0_if.req = req; m0_if.wr = wr; m0_if.addr = addr; m0_if.wdata = wdata; m0_if.lock = lock;
    end else begin
      m1_if.req = req; m1_if.wr = wr; m1_if.addr = addr; m1_if.wdata = wdata; m1_if.lock = lock;
    end
  endtask

  task automatic idle_all();
    drive(0, 0, 0, '0, '0, 0);
    drive(1, 0, 0, '0, '0, 0);
  endtask

  // One clock: check outputs at the falling edge, then advance the model on the rising edge.
  task automatic step();
    int          g;
    bit          r0, r1, wr, lk;
    logic [31:0] ad, wd;
    logic [31:0] e_rd [2];
    @(negedge clk);
    r0 = m0_if.req; r1 = m1_if.req;
    if (lk_owner == 0)      g = r0 ? 0 : -1;
    else if (lk_owner == 1) g = r1 ? 1 : -1;
    else if (r0 && r1)      g = (m_last == 1) ? 0 : 1;
    else if (r0)            g = 0;
    else if (r1)            g = 1;
    else                    g = -1;
    wr = (g == 1) ? m1_if.wr : m0_if.wr;
    ad = (g == 1) ? m1_if.addr : m0_if.addr;
    wd = (g == 1) ? m1_if.wdata : m0_if.wdata;
    for (int n = 0; n < 2; n++) e_rd[n] = (pv && ptag == n) ? pdat : exp_rdata[n];
    chk("gnt0", 32'(m0_if.gnt), 32'(g == 0));
    chk("gnt1", 32'(m1_if.gnt), 32'(g == 1));
    chk("p_wr", 32'(p_wr), (g >= 0) ? 32'(wr) : 32'd0);
    chk("p_addr", p_addr, (g >= 0) ? ad : 32'd0);
    chk("p_wdata", p_wdata, (g >= 0) ? wd : 32'd0);
    chk("rvalid0", 32'(m0_if.rvalid), 32'(pv && ptag == 0));
    chk("rvalid1", 32'(m1_if.rvalid), 32'(pv && ptag == 1));
    chk("rdata0", m0_if.rdata, e_rd[0]);
    chk("rdata1", m1_if.rdata, e_rd[1]);
    if (m0_if.gnt) gseq.push_back(0);
    if (m1_if.gnt) gseq.push_back(1);
    lk = (g == 1) ? m1_if.lock : m0_if.lock;
    @(posedge clk);
    exp_rdata[0] = e_rd[0]; exp_rdata[1] = e_rd[1];
    pv = 0;
    if (g >= 0) begin
      m_last = g;
      if (wr) begin
        if (ad[21:0] == 22'd0) sh_ledr = {22'd0, wd[9:0]};
        if (ad[21:0] == 22'd1) sh_gpio = wd;
      end else begin
        pv = 1; ptag = g; pdat = model_read(ad);
      end
    end
`ifdef PERIPH_ARB_LOCK_EN
    if (lk_owner < 0) begin
      if (g >= 0 && lk && LMAX > 1) begin
        lk_owner = g; lk_n = 1;
      end
    end else if (g == lk_owner) begin
      lk_n++;
      if (!lk || lk_n == LMAX) lk_owner = -1;
    end else if (!(lk_owner == 1 ? r1 : r0) && !(lk_owner == 1 ? m1_if.lock : m0_if.lock)) begin
      lk_owner = -1;
    end
`else
    lk = lk;
`endif
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_gnt0", 32'(m0_if.gnt), 32'd0);
    chk("rst_rvalid1", 32'(m1_if.rvalid), 32'd0);
    chk("rst_rdata0", m0_if.rdata, 32'd0);
    do_reset();

    // 1: m0 write LEDR then read it back.
    drive(0, 1, 1, 32'd0, 32'h3FF, 0); step();
    chk("t1_ledr", 32'(per_ledr), 32'h3FF);
    drive(0, 1, 0, 32'd0, 32'd0, 0);   step();
    idle_all();                        step();
    chk("t1_rdata", m0_if.rdata, 32'h3FF);

    // 2: both masters read every cycle -> grants alternate.
    gseq.delete();
    drive(0, 1, 0, 32'd0, '0, 0);
    drive(1, 1, 0, 32'd1, '0, 0);
    repeat (6) step();
    idle_all(); step();
    chk("t2_ngrants", 32'(gseq.size()), 32'd6);
    for (int i = 1; i < 6 && i < gseq.size(); i++) chk("t2_alternate", 32'(gseq[i] != gseq[i-1]), 32'd1);

    // 3: simultaneous write (m0) and read (m1) of addr 1 after reset.
    do_reset();
    drive(0, 1, 1, 32'd1, 32'hA5, 0);
    drive(1, 1, 0, 32'd1, '0, 0);
    step();
    drive(0, 0, 0, '0, '0, 0); step();
    drive(1, 0, 0, '0, '0, 0); step();
    chk("t3_rdata1", m1_if.rdata, 32'hA5);

    // 4: out-of-range read returns 0, out-of-range write changes nothing.
    drive(0, 1, 0, 32'd5, '0, 0); step();
    idle_all(); step();
    chk("t4_rdata0", m0_if.rdata, 32'd0);
    drive(0, 1, 1, 32'd5, 32'hFFFF_FFFF, 0); step();
    idle_all(); step();
    chk("t4_ledr", 32'(per_ledr), 32'd0);
    chk("t4_gpio", per_gpio, 32'hA5);

    // 5: reset right after a read grant drops the pending response.
    drive(0, 1, 0, 32'd1, '0, 0); step();
    rst = 1'b1;
    #1;
    chk("t5_rvalid0", 32'(m0_if.rvalid), 32'd0);
    chk("t5_gnt0", 32'(m0_if.gnt), 32'd0);
    chk("t5_rdata0", m0_if.rdata, 32'd0);
    chk("t5_p_addr", p_addr, 32'd0);
    @(negedge clk);
    chk("t5_rvalid0_hold", 32'(m0_if.rvalid), 32'd0);
    do_reset();

    // 6: m0 holds lock while m1 also requests.
    gseq.delete();
    drive(0, 1, 0, 32'd0, '0, 1);
    drive(1, 1, 0, 32'd1, '0, 0);
    repeat (6) step();
    idle_all(); step();
`ifdef PERIPH_ARB_LOCK_EN
    chk("t6_g0", 32'(gseq[0]), 32'd0);
    chk("t6_g1", 32'(gseq[1]), 32'd0);
    chk("t6_g2", 32'(gseq[2]), 32'd0);
    chk("t6_g3", 32'(gseq[3]), 32'd1);
`else
    chk("t6_g0", 32'(gseq[0]), 32'd0);
    chk("t6_g1", 32'(gseq[1]), 32'd1);
    chk("t6_g2", 32'(gseq[2]), 32'd0);
    chk("t6_g3", 32'(gseq[3]), 32'd1);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        drive(n, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              ($urandom & 32'hFFC0_0000) | 32'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 2) == 0);
      end
      step();
    end
    idle_all(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
